bullet_pool: RTL and testbench
==============================

BULLET_POOL -- requirements
Module: bullet_pool

Interface
REQ-001 Parameter NUM_SLOTS, default 4: number of concurrent bullets, range 1..8.
REQ-002 Parameter DIR, default -1: travel direction, +1 (rightward) or -1 (leftward).
REQ-003 Parameter STEP_X, default BULLET_STEP_X: pixels moved per tick.
REQ-004 Parameter COOLDOWN, default 8: ticks between accepted shots, range 0..255.
REQ-005 The block SHALL use clock clk; reset rst_n, asynchronous, active-low.
REQ-006 Ports, one per line as name / direction / width / meaning:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- tick  in  1  frame-update strobe; all state changes except reset occur only when tick=1
- fire  in  1  shoot request, sampled on tick
- defend  in  1  shooter is blocking; suppresses fire
- xShooter  in  s11  shooter centre x
- yShooter  in  s10  shooter centre y
- xTarget  in  s11  target centre x
- yTarget  in  s10  target centre y
- targetSquat  in  1  target is squatting; selects reduced half-height
- x  out  NUM_SLOTS×s11  per-slot bullet x, flattened, slot 0 in LSBs
- y  out  NUM_SLOTS×s10  per-slot bullet y, flattened, slot 0 in LSBs
- alive  out  NUM_SLOTS  per-slot existence flag
- full  out  1  all slots alive (combinational from alive)
- hit  out  1  one-cycle pulse, registered, on a tick in which at least one bullet hit
- hitCount  out  8  saturating count of hit ticks

Function
REQ-007 On tick, each alive slot SHALL compute nx = x + DIR·STEP_X; y SHALL be unchanged.
REQ-008 Hit test on nx: |nx − xTarget| < PLAYER_X + BULLET_X AND |y − yTarget| < H + BULLET_Y.
- H = SQUAT_PLAYER_Y when targetSquat=1, else PLAYER_Y.
- All arithmetic SHALL be done in 12-bit signed, so there is no overflow.
REQ-009 A hit slot SHALL clear alive on that tick.
REQ-010 Off-map rule: a slot with nx < −MAP_X + BULLET_X or nx > MAP_X − BULLET_X SHALL clear alive.
- If a slot both hits and leaves the map on the same tick, the hit counts.
REQ-011 The hit output SHALL assert for exactly the clk cycle after any tick with one or more hits.
- Multiple simultaneous hits SHALL produce one pulse.
- Multiple simultaneous hits SHALL increment hitCount by 1.
- hitCount SHALL saturate at 255.
REQ-012 Fire is accepted on tick when fire=1 AND defend=0 AND cooldown=0 AND full=0.
REQ-013 An accepted fire SHALL allocate the lowest-index slot whose alive=0 at the start of the tick.
- That slot's alive SHALL be set.
- Its x SHALL be xShooter + DIR·(PLAYER_X + BULLET_X), and its y SHALL be yShooter.
- The spawned bullet SHALL NOT move or hit-test on its spawn tick.
REQ-014 Slots freed on the current tick SHALL NOT be reused on that same tick.
REQ-015 A rejected fire (full, cooldown active, or defend) SHALL be dropped, not queued.
REQ-016 Cooldown counter behaviour:
- On an accepted fire it SHALL load COOLDOWN.
- Otherwise it SHALL decrement on tick while nonzero.
- COOLDOWN=0 permits a shot every tick.
REQ-017 A dead slot SHALL hold its last x/y; its x/y values are don't-care to consumers when alive=0.
REQ-018 With tick=0, all registers SHALL hold, and fire, defend and the target inputs SHALL be ignored.

Reset
REQ-019 While rst_n=0, the following SHALL be cleared to 0: alive, x, y, cooldown, hit, hitCount.
REQ-020 Reset asserted mid-flight SHALL kill all bullets immediately, with no hit pulse.
- The first tick after release SHALL behave as from power-up.

Structure
REQ-021 BULLET_X, BULLET_Y, PLAYER_X, PLAYER_Y, SQUAT_PLAYER_Y, MAP_X and BULLET_STEP_X SHALL come from GamePkg.
- No local redefinition of these constants is allowed.
REQ-022 One sub-module, bullet_slot, SHALL hold one slot's x, y and alive state plus its move, hit and off-map logic.
- It SHALL be instantiated NUM_SLOTS times via generate.
- Slot allocation, cooldown and hit aggregation SHALL live in bullet_pool.

Verification
REQ-023 Directed scenarios, with NUM_SLOTS=4, COOLDOWN=3, DIR=−1, STEP_X=8, each stimulus followed by its required response:
- Reset release, then fire=1 on tick 1 → alive=0001; slot0 x = xShooter−PLAYER_X−BULLET_X, y = yShooter; the next tick gives x −8.
- fire held high every tick → spawns on ticks 1, 5, 9, 13; alive=1111, full=1; the fire on tick 17 is dropped while all four are in flight.
- Target placed at spawn_x−8, same y, targetSquat=0 → a hit on the first move tick, hit=1 for one cycle, hitCount=1, slot cleared.
- Same geometry, but with yTarget such that |Δy| is in [SQUAT_PLAYER_Y+BULLET_Y, PLAYER_Y+BULLET_Y) and targetSquat=1 → no hit; the bullet continues.
- Two slots hitting on the same tick → a single hit pulse, hitCount +1; bullet reaching −MAP_X+BULLET_X → alive cleared, no hit.
- defend=1 with fire=1 → no spawn and cooldown unchanged; rst_n pulsed low mid-flight → alive=0000 and hitCount=0 asynchronously.

Source files
------------

// File: rtl/bullet_pool_pkg.sv
`default_nettype none
// ============================================================================
// Module   : GamePkg
// Brief    : Shared game geometry constants (half-extents, map bounds, speed)
//            and the coordinate widths used by the bullet pool.
// Revision : 1.0 - initial release
// ============================================================================
package GamePkg;

  // Half-widths / half-heights in pixels, measured from an object's centre.
  localparam int BULLET_X       = 2;
  localparam int BULLET_Y       = 2;
  localparam int PLAYER_X       = 8;
  localparam int PLAYER_Y       = 16;
  localparam int SQUAT_PLAYER_Y = 8;

  // Playfield half-width; x runs from -MAP_X to +MAP_X.
  localparam int MAP_X          = 320;

  // Default bullet speed in pixels per frame tick.
  localparam int BULLET_STEP_X  = 4;

  // Signed coordinate widths.
  localparam int XW = 11;
  localparam int YW = 10;

endpackage
`default_nettype wire

// File: rtl/bullet_pool_slot.sv
`default_nettype none
// ============================================================================
// Module   : bullet_slot
// Brief    : One bullet: position/alive state, per-tick move, target hit test
//            and off-map kill. Hit test runs on the moved position.
// Revision : 1.0 - initial release
// ============================================================================
module bullet_slot
  import GamePkg::*;
#(
  parameter int DIR    = -1,
  parameter int STEP_X = BULLET_STEP_X
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 spawn,
  input  logic signed [XW-1:0] spawn_x,
  input  logic signed [YW-1:0] spawn_y,
  input  logic signed [XW-1:0] x_target,
  input  logic signed [YW-1:0] y_target,
  input  logic                 target_squat,
  output logic signed [XW-1:0] x,
  output logic signed [YW-1:0] y,
  output logic                 alive,
  output logic                 hit
);

  // 12-bit signed working precision keeps every difference in range.
  localparam logic signed [11:0] DELTA     = 12'(DIR * STEP_X);
  localparam logic signed [11:0] HIT_X     = 12'(PLAYER_X + BULLET_X);
  localparam logic signed [11:0] HIT_Y     = 12'(PLAYER_Y + BULLET_Y);
  localparam logic signed [11:0] HIT_Y_SQ  = 12'(SQUAT_PLAYER_Y + BULLET_Y);
  localparam logic signed [11:0] LEFT_LIM  = 12'(BULLET_X - MAP_X);
  localparam logic signed [11:0] RIGHT_LIM = 12'(MAP_X - BULLET_X);

  logic signed [11:0] nx;
  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic signed [11:0] adx;
  logic signed [11:0] ady;
  logic signed [11:0] reach_y;
  logic               off_map;

  // Next position, distances to target, and the hit / off-map decisions.
  always_comb begin
    nx      = {x[XW-1], x} + DELTA;
    dx      = nx - {x_target[XW-1], x_target};
    dy      = {{(12-YW){y[YW-1]}}, y} - {{(12-YW){y_target[YW-1]}}, y_target};
    adx     = dx[11] ? -dx : dx;
    ady     = dy[11] ? -dy : dy;
    reach_y = target_squat ? HIT_Y_SQ : HIT_Y;
    off_map = (nx < LEFT_LIM) || (nx > RIGHT_LIM);
    hit     = tick && alive && (adx < HIT_X) && (ady < reach_y);
  end

  // Slot state: spawn loads a fresh bullet (no move that tick), otherwise an
  // alive bullet advances and dies on hit or on leaving the map.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x     <= '0;
      y     <= '0;
      alive <= 1'b0;
    end else if (tick) begin
      if (spawn) begin
        x     <= spawn_x;
        y     <= spawn_y;
        alive <= 1'b1;
      end else if (alive) begin
        x     <= nx[XW-1:0];
        alive <= !(hit || off_map);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bullet_pool.sv
`default_nettype none
// ============================================================================
// Module   : bullet_pool
// Brief    : Pool of NUM_SLOTS bullets with fire cooldown, lowest-free-slot
//            allocation, and aggregated hit pulse / saturating hit counter.
// Revision : 1.0 - initial release
// ============================================================================
module bullet_pool
  import GamePkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int DIR       = -1,
  parameter int STEP_X    = BULLET_STEP_X,
  parameter int COOLDOWN  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           tick,
  input  logic                           fire,
  input  logic                           defend,
  input  logic signed [XW-1:0]           xShooter,
  input  logic signed [YW-1:0]           yShooter,
  input  logic signed [XW-1:0]           xTarget,
  input  logic signed [YW-1:0]           yTarget,
  input  logic                           targetSquat,
  output logic        [NUM_SLOTS*XW-1:0] x,
  output logic        [NUM_SLOTS*YW-1:0] y,
  output logic        [NUM_SLOTS-1:0]    alive,
  output logic                           full,
  output logic                           hit,
  output logic        [7:0]              hitCount
);

  localparam logic signed [11:0] SPAWN_OFF = 12'(DIR * (PLAYER_X + BULLET_X));

  logic [7:0]           cooldown;
  logic                 accept;
  logic [NUM_SLOTS-1:0] spawn;
  logic [NUM_SLOTS-1:0] slot_hit;
  logic signed [11:0]   spawn_x;
  logic                 found;

  assign full = &alive;

  // Accept a shot and steer it to the lowest slot that is dead right now;
  // slots freed during this tick are still alive here, so never reused.
  always_comb begin
    accept  = tick && fire && !defend && (cooldown == 8'd0) && !full;
    spawn_x = {xShooter[XW-1], xShooter} + SPAWN_OFF;
    spawn   = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!alive[i] && !found) begin
        spawn[i] = accept;
        found    = 1'b1;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      bullet_slot #(
        .DIR    (DIR),
        .STEP_X (STEP_X)
      ) u_slot (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .spawn        (spawn[g]),
        .spawn_x      (spawn_x[XW-1:0]),
        .spawn_y      (yShooter),
        .x_target     (xTarget),
        .y_target     (yTarget),
        .target_squat (targetSquat),
        .x            (x[g*XW +: XW]),
        .y            (y[g*YW +: YW]),
        .alive        (alive[g]),
        .hit          (slot_hit[g])
      );
    end
  endgenerate

  // Cooldown reloads on an accepted shot, otherwise counts down per tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cooldown <= 8'd0;
    end else if (accept) begin
      cooldown <= 8'(COOLDOWN);
    end else if (tick && (cooldown != 8'd0)) begin
      cooldown <= cooldown - 8'd1;
    end
  end

  // One hit pulse per tick with any hits; counter saturates at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit      <= 1'b0;
      hitCount <= 8'd0;
    end else begin
      hit <= tick && (|slot_hit);
      if (tick && (|slot_hit) && (hitCount != 8'hFF)) begin
        hitCount <= hitCount + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bullet_pool.sv
`default_nettype none
// ============================================================================
// Module   : tb_bullet_pool
// Brief    : Directed scoreboard bench for bullet_pool (4 slots, cooldown 3,
//            leftward, 8 px/tick).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bullet_pool;
  import GamePkg::*;

  localparam int NS = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  tick = 1'b0;
  logic                  fire = 1'b0;
  logic                  defend = 1'b0;
  logic signed [XW-1:0]  xShooter = 11'sd100;
  logic signed [YW-1:0]  yShooter = 10'sd50;
  logic signed [XW-1:0]  xTarget = 11'sd500;
  logic signed [YW-1:0]  yTarget = 10'sd200;
  logic                  targetSquat = 1'b0;
  logic [NS*XW-1:0]      x;
  logic [NS*YW-1:0]      y;
  logic [NS-1:0]         alive;
  logic                  full;
  logic                  hit;
  logic [7:0]            hitCount;

  bullet_pool #(
    .NUM_SLOTS (NS),
    .DIR       (-1),
    .STEP_X    (8),
    .COOLDOWN  (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .fire        (fire),
    .defend      (defend),
    .xShooter    (xShooter),
    .yShooter    (yShooter),
    .xTarget     (xTarget),
    .yTarget     (yTarget),
    .targetSquat (targetSquat),
    .x           (x),
    .y           (y),
    .alive       (alive),
    .full        (full),
    .hit         (hit),
    .hitCount    (hitCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] al;
    logic       fu;
    logic       h;
    logic [7:0] cnt;
    int         slot;
    int         ex;
    int         ey;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   fails   = 0;
  logic tick_d  = 1'b0;
  logic rst_chk = 1'b0;
  logic done    = 1'b0;
  logic reported = 1'b0;

  task automatic cmp(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(posedge clk) tick_d <= tick;

  // Monitor: after each tick (or during a reset probe) pop and compare.
  always @(negedge clk) begin
    exp_t e;
    logic signed [XW-1:0] xs;
    logic signed [YW-1:0] ys;
    if (done && !reported) begin
      reported = 1'b1;
      cmp("scoreboard_drained", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
    end else if (tick_d || rst_chk) begin
      if (sbq.size() == 0) begin
        cmp("scoreboard_underflow", 1, 0);
      end else begin
        e = sbq.pop_front();
        cmp({e.name, ".alive"}, int'(alive), int'(e.al));
        cmp({e.name, ".full"},  int'(full),  int'(e.fu));
        cmp({e.name, ".hit"},   int'(hit),   int'(e.h));
        cmp({e.name, ".hitCount"}, int'(hitCount), int'(e.cnt));
        if (e.slot >= 0) begin
          xs = x[e.slot*XW +: XW];
          ys = y[e.slot*YW +: YW];
          cmp({e.name, ".x"}, int'(xs), e.ex);
          cmp({e.name, ".y"}, int'(ys), e.ey);
        end
      end
    end else if (rst_n) begin
      cmp("hit_idle", int'(hit), 0);
    end
  end

  task automatic push(input string nm, input logic [3:0] al, input logic fu,
                      input logic h, input logic [7:0] c, input int s,
                      input int ex, input int ey);
    exp_t e;
    e.name = nm; e.al = al; e.fu = fu; e.h = h; e.cnt = c;
    e.slot = s; e.ex = ex; e.ey = ey;
    sbq.push_back(e);
  endtask

  task automatic do_tick(input string nm, input logic [3:0] al, input logic fu,
                         input logic h, input logic [7:0] c, input int s,
                         input int ex, input int ey);
    push(nm, al, fu, h, c, s, ex, ey);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  // Reset is asserted just after a rising edge and probed on the following
  // falling edge, before any further rising edge can occur.
  task automatic do_reset(input string nm);
    @(posedge clk);
    #1;
    push(nm, 4'b0000, 1'b0, 1'b0, 8'd0, 0, 0, 0);
    rst_chk = 1'b1;
    rst_n   = 1'b0;
    @(negedge clk);
    #1;
    rst_chk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fire = 1'b0; defend = 1'b0; targetSquat = 1'b0;
    xShooter = 11'sd100; yShooter = 10'sd50;
    xTarget = 11'sd500; yTarget = 10'sd200;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Spawn position and first move.
    do_reset("rst0");
    fire = 1'b1;
    do_tick("s1_spawn", 4'b0001, 1'b0, 1'b0, 8'd0, 0, 90, 50);
    fire = 1'b0;
    do_tick("s1_move", 4'b0001, 1'b0, 1'b0, 8'd0, 0, 82, 50);

    // Fire held: spawns every fourth tick until full, then dropped.
    do_reset("rst1");
    fire = 1'b1;
    for (int t = 1; t <= 18; t++) begin
      logic [3:0] al;
      al = (t < 5) ? 4'b0001 : (t < 9) ? 4'b0011 : (t < 13) ? 4'b0111 : 4'b1111;
      if (t == 17)
        do_tick($sformatf("s2_t%0d", t), al, 1'b1, 1'b0, 8'd0, 3, 58, 50);
      else
        do_tick($sformatf("s2_t%0d", t), al, (t >= 13), 1'b0, 8'd0, 0, 90 - 8*(t-1), 50);
    end
    fire = 1'b0;

    // Target one step ahead: no hit on spawn tick, hit on first move.
    do_reset("rst2");
    xTarget = 11'sd82; yTarget = 10'sd50;
    fire = 1'b1;
    do_tick("s3_spawn", 4'b0001, 1'b0, 1'b0, 8'd0, 0, 90, 50);
    fire = 1'b0;
    do_tick("s3_hit", 4'b0000, 1'b0, 1'b1, 8'd1, -1, 0, 0);
    do_tick("s3_after", 4'b0000, 1'b0, 1'b0, 8'd1, -1, 0, 0);

    // Squat reduces vertical reach: |dy|=12 misses squatting, hits standing.
    do_reset("rst3");
    xTarget = 11'sd82; yTarget = 10'sd62; targetSquat = 1'b1;
    fire = 1'b1;
    do_tick("s4_spawn", 4'b0001, 1'b0, 1'b0, 8'd0, 0, 90, 50);
    fire = 1'b0;
    do_tick("s4_squat_miss", 4'b0001, 1'b0, 1'b0, 8'd0, 0, 82, 50);
    targetSquat = 1'b0;
    do_tick("s4_stand_hit", 4'b0000, 1'b0, 1'b1, 8'd1, -1, 0, 0);

    // Two bullets at the same x hit together: one pulse, count +1.
    do_reset("rst4");
    fire = 1'b1;
    do_tick("s5_spawn0", 4'b0001, 1'b0, 1'b0, 8'd0, 0, 90, 50);
    fire = 1'b0;
    do_tick("s5_t2", 4'b0001, 1'b0, 1'b0, 8'd0, 0, 82, 50);
    do_tick("s5_t3", 4'b0001, 1'b0, 1'b0, 8'd0, 0, 74, 50);
    do_tick("s5_t4", 4'b0001, 1'b0, 1'b0, 8'd0, 0, 66, 50);
    fire = 1'b1; xShooter = 11'sd68;
    do_tick("s5_spawn1", 4'b0011, 1'b0, 1'b0, 8'd0, 1, 58, 50);
    fire = 1'b0; xTarget = 11'sd50; yTarget = 10'sd50;
    do_tick("s5_double_hit", 4'b0000, 1'b0, 1'b1, 8'd1, -1, 0, 0);
    xTarget = 11'sd500; yTarget = 10'sd200;
    do_tick("s5_t7", 4'b0000, 1'b0, 1'b0, 8'd1, -1, 0, 0);
    do_tick("s5_t8", 4'b0000, 1'b0, 1'b0, 8'd1, -1, 0, 0);

    // Left edge: -318 is still on the map, -326 is not; no hit counted.
    fire = 1'b1; xShooter = -11'sd300;
    do_tick("s5_edge_spawn", 4'b0001, 1'b0, 1'b0, 8'd1, 0, -310, 50);
    fire = 1'b0;
    do_tick("s5_edge_limit", 4'b0001, 1'b0, 1'b0, 8'd1, 0, -318, 50);
    do_tick("s5_edge_off", 4'b0000, 1'b0, 1'b0, 8'd1, -1, 0, 0);
    do_tick("s5_cd_drain", 4'b0000, 1'b0, 1'b0, 8'd1, -1, 0, 0);

    // Defend blocks fire without reloading cooldown; next tick fires.
    fire = 1'b1; defend = 1'b1; xShooter = 11'sd100;
    do_tick("s6_defend", 4'b0000, 1'b0, 1'b0, 8'd1, -1, 0, 0);
    defend = 1'b0;
    do_tick("s6_fire", 4'b0001, 1'b0, 1'b0, 8'd1, 0, 90, 50);
    fire = 1'b0;
    do_tick("s6_move", 4'b0001, 1'b0, 1'b0, 8'd1, 0, 82, 50);

    // Mid-flight asynchronous reset.
    do_reset("s6_midflight_rst");
    repeat (2) @(negedge clk);
    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
